fifo_drain_ctrl: RTL and testbench
==================================

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port drain_en, input, 1 bit: enables draining; low aborts.
REQ-004 SHALL have port burst_sel, input, 2 bits: burst length; 00=1, 01=4, 10=8, 11=12 words.
REQ-005 SHALL have port fifo_empty, input, 1 bit: source FIFO empty flag.
REQ-006 SHALL have port fifo_count, input, 5 bits: source FIFO occupancy, 0..16.
REQ-007 SHALL have port fifo_rd_data, input, 16 bits: FIFO head word, valid combinationally in the same cycle as fifo_rd_en.
REQ-008 SHALL have port fifo_rd_en, output, 1 bit: pop request; FIFO pointer advances on the following edge.
REQ-009 SHALL have port tx_valid, output, 1 bit: output word valid.
REQ-010 SHALL have port tx_ready, input, 1 bit: sink accepts the word when tx_valid and tx_ready are both high.
REQ-011 SHALL have port tx_data, output, 16 bits: output word.
REQ-012 SHALL have port tx_last, output, 1 bit: marks the final word of a burst; qualified by tx_valid.
REQ-013 SHALL have port done_clr, input, 1 bit: clears done_intr.
REQ-014 SHALL have port done_intr, output, 1 bit: sticky burst-complete flag.

Function
REQ-015 SHALL implement three states: IDLE, BURST and DONE.
REQ-016 IDLE->BURST SHALL occur when drain_en=1 and fifo_count >= burst length.
- On entry, the 4-bit remaining counter SHALL load the burst length.
REQ-017 In BURST, fifo_rd_en SHALL be driven combinationally as: drain_en & ~fifo_empty & (remaining>0) & (~tx_valid | tx_ready).
REQ-018 On every edge where fifo_rd_en=1, the block SHALL:
- capture fifo_rd_data into tx_data;
- set tx_valid;
- decrement remaining;
- set tx_last if remaining was 1.
REQ-019 Latency SHALL be one cycle: a word read in cycle N appears on tx_data/tx_valid in cycle N+1.
REQ-020 Throughput SHALL be one word per cycle while tx_ready=1 and the FIFO is non-empty.
REQ-021 On acceptance without a simultaneous read, tx_valid SHALL clear next cycle; tx_data SHALL hold its last value.
REQ-022 While tx_valid=1 and tx_ready=0, tx_data and tx_last SHALL remain stable and fifo_rd_en SHALL be 0.
REQ-023 fifo_empty=1 mid-burst SHALL stall reads without error; the burst SHALL resume when data arrives, with no timeout.
REQ-024 BURST->DONE SHALL occur on the edge where the word with tx_last is accepted.
REQ-025 DONE SHALL last exactly one cycle, set done_intr, then go to IDLE.
- A new burst SHALL be evaluated in IDLE, giving a minimum 2-cycle gap between bursts.
REQ-026 If drain_en falls during BURST:
- reads SHALL stop immediately (same cycle, combinational);
- any pending tx word SHALL still be offered until accepted;
- the block SHALL then return to IDLE without setting done_intr.
REQ-027 burst_sel SHALL be sampled only on IDLE->BURST; changes mid-burst SHALL have no effect.
REQ-028 done_clr SHALL take priority over a simultaneous set; done_intr SHALL otherwise hold until cleared.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously force:
- state to IDLE;
- remaining to 0;
- tx_valid, tx_last and done_intr to 0;
- tx_data to 16'h0000.
- fifo_rd_en SHALL be 0 throughout reset.
REQ-030 Reset mid-burst SHALL discard the pending word and the remaining count.
- After rst_n rises, operation SHALL resume from IDLE on the next edge.

Configuration
REQ-031 With macro FIFO_DRAIN_STAT_EN defined, the block SHALL add port word_cnt, output, 16 bits.
- word_cnt SHALL increment on each tx acceptance and wrap from 16'hFFFF to 0.
- word_cnt SHALL reset to 0 on rst_n low and when drain_en=0.
REQ-032 Without FIFO_DRAIN_STAT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Burst of 1: burst_sel=00, fifo_count=1, tx_ready=1 -> fifo_rd_en for 1 cycle; next cycle tx_valid=1, tx_last=1, tx_data=head; done_intr=1 two cycles later.
REQ-034 Burst of 4 with backpressure: burst_sel=01, FIFO holds A1..A4, tx_ready low for 3 cycles on word 2 -> word 2 held stable; output order A1..A4; tx_last only on A4; exactly 4 pops.
REQ-035 Threshold gate: burst_sel=10, fifo_count=7 -> stays IDLE, no pops; fifo_count becomes 8 -> BURST; 8 words transferred.
REQ-036 Underrun mid-burst: burst_sel=11, 12 words entered, fifo_empty asserted after 5 pops for 4 cycles -> no pops during the stall; all 12 words transferred; done_intr=1.
REQ-037 Abort: drain_en falls after 2 of 8 words -> no further pops; pending word accepted; IDLE; done_intr stays 0.
REQ-038 Set/clear collision: done_clr=1 in the DONE cycle -> done_intr stays 0. With FIFO_DRAIN_STAT_EN, after the 12-word burst -> word_cnt=12.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - drains fixed-length bursts from a source FIFO onto a valid/ready stream.
// Define FIFO_DRAIN_STAT_EN to add the word_cnt accepted-word counter port.
module fifo_drain_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        drain_en,
    input  logic [1:0]  burst_sel,
    input  logic        fifo_empty,
    input  logic [4:0]  fifo_count,
    input  logic [15:0] fifo_rd_data,
    output logic        fifo_rd_en,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_last,
    input  logic        done_clr,
`ifdef FIFO_DRAIN_STAT_EN
    output logic [15:0] word_cnt,
`endif
    output logic        done_intr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [3:0]  burst_len;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_last_q, tx_last_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        done_q, done_d;
    logic        tx_accept;

    always_comb begin
        case (burst_sel)
            2'b00:   burst_len = 4'd1;
            2'b01:   burst_len = 4'd4;
            2'b10:   burst_len = 4'd8;
            default: burst_len = 4'd12;
        endcase
    end

    assign tx_accept = tx_valid_q & tx_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        tx_data_d   = tx_data_q;
        done_d      = done_q;
        fifo_rd_en  = 1'b0;

        // tx_data keeps its last value after acceptance; only the qualifiers drop
        if (tx_accept) begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (drain_en && (fifo_count >= {1'b0, burst_len})) begin
                    state_d     = S_BURST;
                    remaining_d = burst_len;
                end
            end
            S_BURST: begin
                fifo_rd_en = drain_en & ~fifo_empty & (remaining_q != 4'd0)
                           & (~tx_valid_q | tx_ready);
                if (fifo_rd_en) begin
                    tx_data_d   = fifo_rd_data;
                    tx_valid_d  = 1'b1;
                    tx_last_d   = (remaining_q == 4'd1);
                    remaining_d = remaining_q - 4'd1;
                end
                // an abort waits until any word already on the bus has been taken
                if (tx_accept && tx_last_q) begin
                    state_d = S_DONE;
                end else if (!drain_en && (!tx_valid_q || tx_accept)) begin
                    state_d     = S_IDLE;
                    remaining_d = 4'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (done_clr) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= 4'd0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_data_q   <= 16'h0000;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            tx_data_q   <= tx_data_d;
            done_q      <= done_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;
    assign tx_data   = tx_data_q;
    assign done_intr = done_q;

`ifdef FIFO_DRAIN_STAT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= 16'h0000;
        end else if (!drain_en) begin
            word_cnt_q <= 16'h0000;
        end else if (tx_accept) begin
            word_cnt_q <= word_cnt_q + 16'h0001;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - randomized scoreboard bench for fifo_drain_ctrl.
module tb_fifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        drain_en;
    logic [1:0]  burst_sel;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_last;
    logic        done_clr;
    logic        done_intr;
`ifdef FIFO_DRAIN_STAT_EN
    logic [15:0] word_cnt;
`endif

    always #5 clk = ~clk;

    fifo_drain_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .drain_en     (drain_en),
        .burst_sel    (burst_sel),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .done_clr     (done_clr),
`ifdef FIFO_DRAIN_STAT_EN
        .word_cnt     (word_cnt),
`endif
        .done_intr    (done_intr)
    );

    logic [15:0] src_q[$];
    logic [15:0] ref_q[$];
    logic [16:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    bit rnd_ready = 1'b0;
    int stall_pct = 0;
    int stall_at  = -1;
    int stall_len = 0;
    int stall_left = 0;
    int hold_idx  = -1;
    int hold_len  = 0;
    int hold_cnt  = 0;
    int pops      = 0;
    int accepts   = 0;

    bit          s_rd_en, s_valid, s_last, s_done;
    logic [15:0] s_data;

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endfunction

    function automatic int blen(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 12;
        endcase
    endfunction

    task automatic fifo_refresh();
        fifo_empty   = (src_q.size() == 0) || (stall_left > 0);
        fifo_count   = 5'(src_q.size());
        fifo_rd_data = (src_q.size() > 0) ? src_q[0] : 16'h0000;
    endtask

    task automatic load(input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            src_q.push_back(w);
            ref_q.push_back(w);
        end
        fifo_refresh();
    endtask

    task automatic expect_burst(input int len);
        logic [15:0] w;
        for (int i = 0; i < len; i++) begin
            w = ref_q.pop_front();
            exp_q.push_back({(i == len - 1), w});
        end
    endtask

    task automatic flush_src();
        src_q.delete();
        ref_q.delete();
        fifo_refresh();
    endtask

    // One clock: sample mid-cycle, then apply FIFO pop and new sink/source conditions after the edge
    task automatic step();
        @(negedge clk);
        s_rd_en = fifo_rd_en;
        s_valid = tx_valid;
        s_last  = tx_last;
        s_data  = tx_data;
        s_done  = done_intr;
        if (tx_valid && tx_ready) accepts++;
        @(posedge clk);
        #1;
        if (s_rd_en && src_q.size() > 0) begin
            void'(src_q.pop_front());
            pops++;
        end
        if (stall_left > 0) stall_left--;
        if (stall_at >= 0 && pops == stall_at) begin
            stall_left = stall_len;
            stall_at   = -1;
        end else if (stall_pct > 0 && stall_left == 0 && $urandom_range(99) < stall_pct) begin
            stall_left = 1;
        end
        if (rnd_ready) begin
            tx_ready = ($urandom_range(99) < 75);
        end else if (hold_idx >= 0 && tx_valid && accepts == hold_idx && hold_cnt < hold_len) begin
            tx_ready = 1'b0;
            hold_cnt++;
        end else begin
            tx_ready = 1'b1;
        end
        fifo_refresh();
    endtask

    task automatic run_phase(input logic [1:0] sel, input int extra);
        int len;
        int t;
        len = blen(sel);
        if (src_q.size() >= len) flush_src();
        burst_sel = sel;
        load(len + extra - src_q.size());
        expect_burst(len);
        pops    = 0;
        accepts = 0;
        drain_en = 1'b1;
        t = 0;
        s_done = 1'b0;
        while (!s_done && t < 600) begin
            step();
            t++;
        end
        chk(s_done, "done_set", 32'(s_done), 32'd1);
        chk(pops == len, "pop_count", 32'(pops), 32'(len));
        chk(exp_q.size() == 0, "burst_words_out", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_DRAIN_STAT_EN
        chk(word_cnt == 16'(len), "word_cnt", 32'(word_cnt), 32'(len));
`endif
        done_clr = 1'b1;
        step();
        done_clr = 1'b0;
        drain_en = 1'b0;
        step();
        chk(!s_done, "done_cleared", 32'(s_done), 32'd0);
    endtask

    task automatic burst1(input bit clr);
        logic [15:0] head;
        int t;
        burst_sel = 2'b00;
        if (src_q.size() > 0) flush_src();
        load(1);
        head = ref_q[0];
        expect_burst(1);
        pops = 0;
        drain_en = 1'b1;
        t = 0;
        s_rd_en = 1'b0;
        while (!s_rd_en && t < 20) begin
            step();
            t++;
        end
        chk(s_rd_en, "b1_pop_seen", 32'(s_rd_en), 32'd1);
        step();
        chk(s_valid && s_last, "b1_valid_last", {30'd0, s_valid, s_last}, 32'd3);
        chk(s_data == head, "b1_data", 32'(s_data), 32'(head));
        if (clr) done_clr = 1'b1;
        step();
        done_clr = 1'b0;
        chk(!s_done, "b1_done_in_done_state", 32'(s_done), 32'd0);
        step();
        chk(s_done == !clr, "b1_done_after", 32'(s_done), 32'(!clr));
        chk(pops == 1, "b1_pops", 32'(pops), 32'd1);
        done_clr = 1'b1;
        step();
        done_clr = 1'b0;
        drain_en = 1'b0;
        step();
    endtask

    // Scoreboard monitor: pops expected words on every acceptance and polices pop/hold rules
    initial begin
        bit          prev_hold;
        logic [15:0] prev_data;
        logic        prev_last;
        logic [16:0] e;
        prev_hold = 1'b0;
        prev_data = 16'h0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_hold)
                    chk(tx_valid && tx_data == prev_data && tx_last == prev_last, "hold_stable",
                        {15'd0, tx_valid, tx_last, tx_data}, {15'd0, 1'b1, prev_last, prev_data});
                if (tx_valid && !tx_ready)
                    chk(!fifo_rd_en, "no_pop_backpressure", 32'(fifo_rd_en), 32'd0);
                if (fifo_empty)
                    chk(!fifo_rd_en, "no_pop_empty", 32'(fifo_rd_en), 32'd0);
                if (!drain_en)
                    chk(!fifo_rd_en, "no_pop_disabled", 32'(fifo_rd_en), 32'd0);
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_word", 32'({tx_last, tx_data}), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({tx_last, tx_data} == e, "tx_word", 32'({tx_last, tx_data}), 32'(e));
                    end
                end
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
                prev_last = tx_last;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sel;
        int         len;
        int         t;
        rst_n     = 1'b0;
        drain_en  = 1'b1;
        burst_sel = 2'b00;
        tx_ready  = 1'b1;
        done_clr  = 1'b0;
        load(4);
        repeat (3) @(negedge clk);
        chk(!tx_valid, "rst_tx_valid", 32'(tx_valid), 32'd0);
        chk(!tx_last, "rst_tx_last", 32'(tx_last), 32'd0);
        chk(tx_data == 16'h0, "rst_tx_data", 32'(tx_data), 32'd0);
        chk(!done_intr, "rst_done", 32'(done_intr), 32'd0);
        chk(!fifo_rd_en, "rst_rd_en", 32'(fifo_rd_en), 32'd0);
        drain_en = 1'b0;
        flush_src();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        burst1(1'b0);
        burst1(1'b1);

        hold_idx = 1;
        hold_len = 3;
        hold_cnt = 0;
        run_phase(2'b01, 0);
        hold_idx = -1;

        burst_sel = 2'b10;
        load(7);
        pops = 0;
        drain_en = 1'b1;
        repeat (10) step();
        chk(pops == 0, "threshold_gate", 32'(pops), 32'd0);
        run_phase(2'b10, 0);

        stall_at  = 5;
        stall_len = 4;
        run_phase(2'b11, 0);

        burst_sel = 2'b10;
        flush_src();
        load(8);
        exp_q.push_back({1'b0, ref_q[0]});
        exp_q.push_back({1'b0, ref_q[1]});
        pops = 0;
        drain_en = 1'b1;
        t = 0;
        while (pops < 2 && t < 50) begin
            step();
            t++;
        end
        drain_en = 1'b0;
        repeat (5) step();
        chk(pops == 2, "abort_pops", 32'(pops), 32'd2);
        chk(exp_q.size() == 0, "abort_pending_out", 32'(exp_q.size()), 32'd0);
        chk(!s_done, "abort_no_done", 32'(s_done), 32'd0);
        flush_src();

        burst_sel = 2'b11;
        load(12);
        expect_burst(12);
        pops = 0;
        drain_en = 1'b1;
        t = 0;
        while (pops < 3 && t < 50) begin
            step();
            t++;
        end
        rst_n = 1'b0;
        #1;
        chk(!tx_valid, "rst_mid_valid", 32'(tx_valid), 32'd0);
        chk(!fifo_rd_en, "rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
        chk(tx_data == 16'h0, "rst_mid_data", 32'(tx_data), 32'd0);
        exp_q.delete();
        flush_src();
        drain_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        rnd_ready = 1'b1;
        stall_pct = 15;
        for (int i = 0; i < 20; i++) begin
            sel = 2'($urandom_range(3));
            len = blen(sel);
            run_phase(sel, int'($urandom_range((len - 1 < 16 - len) ? len - 1 : 16 - len)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
